mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus the writeback stage of the 16-bit pipelined CPU.
//  - Captures the Memory-stage results: load data, ALU/jal result, destination, write enable.
//  - Drives the register-file write port.
//  - Owns the architectural condition-flag register (zr/ne/ov). Memory-stage branch logic reads it.
//  - Holds a sticky halt and an optional retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 141 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback port, architectural flags, sticky halt.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] memData,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              memToReg,
    input  logic              regWe_in,
    input  logic [REG_AW-1:0] dst_in,
    input  logic              zr_in,
    input  logic              ne_in,
    input  logic              ov_in,
    input  logic              zrEn_MEM,
    input  logic              neEn_MEM,
    input  logic              ovEn_MEM,
    input  logic              hlt_in,
    output logic [DATA_W-1:0] wbData,
    output logic [REG_AW-1:0] wbDst,
    output logic              wbWe,
    output logic              zr,
    output logic              ne,
    output logic              ov,
    output logic              hlt,
    output logic [CNT_W-1:0]  retireCnt
);

    // Pipeline control: stall freezes everything and beats flush; once a HLT
    // is stored the stage never captures again, so the halt is self-sustaining.
    logic              valid_q, valid_d;
    logic              m2r_q, m2r_d;
    logic              regwe_q, regwe_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] memdata_q, memdata_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              hlt_q, hlt_d;
    logic              zr_q, zr_d;
    logic              ne_q, ne_d;
    logic              ov_q, ov_d;

    logic cap;
    logic retire;

    assign hlt    = valid_q & hlt_q;
    assign cap    = !stall & !hlt;
    assign retire = cap & !flush & valid_in;

    always_comb begin
        valid_d   = valid_q;
        m2r_d     = m2r_q;
        regwe_d   = regwe_q;
        dst_d     = dst_q;
        memdata_d = memdata_q;
        alu_d     = alu_q;
        hlt_d     = hlt_q;
        zr_d      = zr_q;
        ne_d      = ne_q;
        ov_d      = ov_q;
        if (cap) begin
            if (flush) begin
                valid_d = 1'b0;
                regwe_d = 1'b0;
                hlt_d   = 1'b0;
            end else begin
                valid_d   = valid_in;
                m2r_d     = memToReg;
                regwe_d   = regWe_in;
                dst_d     = dst_in;
                memdata_d = memData;
                alu_d     = aluResult;
                hlt_d     = hlt_in;
            end
        end
        // Flags come straight from the instruction leaving MEM, so the next
        // instruction sees them when it reaches MEM one cycle later.
        if (retire) begin
            if (zrEn_MEM) zr_d = zr_in;
            if (neEn_MEM) ne_d = ne_in;
            if (ovEn_MEM) ov_d = ov_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            m2r_q     <= 1'b0;
            regwe_q   <= 1'b0;
            dst_q     <= '0;
            memdata_q <= '0;
            alu_q     <= '0;
            hlt_q     <= 1'b0;
            zr_q      <= 1'b0;
            ne_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            m2r_q     <= m2r_d;
            regwe_q   <= regwe_d;
            dst_q     <= dst_d;
            memdata_q <= memdata_d;
            alu_q     <= alu_d;
            hlt_q     <= hlt_d;
            zr_q      <= zr_d;
            ne_q      <= ne_d;
            ov_q      <= ov_d;
        end
    end

    assign wbData = m2r_q ? memdata_q : alu_q;
    assign wbDst  = dst_q;
    assign wbWe   = valid_q & regwe_q & !hlt;
    assign zr     = zr_q;
    assign ne     = ne_q;
    assign ov     = ov_q;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign retireCnt = cnt_q;
`else
    assign retireCnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus stall/flush/halt/reset/wrap sequences.
module tb_mem_wb_stage;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 4;
`ifdef RETIRE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        m2r;
        logic        we;
        logic [3:0]  dst;
        logic [15:0] mem;
        logic [15:0] alu;
        logic [2:0]  fin;   // {zr, ne, ov}
        logic [2:0]  fen;   // {zrEn, neEn, ovEn}
        logic        hlt;
    } in_t;

    typedef struct packed {
        logic        care;  // wbDst/wbData checked only when set
        logic        we;
        logic [3:0]  dst;
        logic [15:0] data;
        logic [2:0]  flags;
        logic        hlt;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } rec_t;

    localparam int EW = $bits(exp_t);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, valid_in, memToReg, regWe_in, hlt_in;
    logic [DATA_W-1:0] memData, aluResult;
    logic [REG_AW-1:0] dst_in;
    logic              zr_in, ne_in, ov_in, zrEn_MEM, neEn_MEM, ovEn_MEM;
    logic [DATA_W-1:0] wbData;
    logic [REG_AW-1:0] wbDst;
    logic              wbWe, zr, ne, ov, hlt;
    logic [CNT_W-1:0]  retireCnt;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .memData(memData), .aluResult(aluResult), .memToReg(memToReg), .regWe_in(regWe_in),
        .dst_in(dst_in), .zr_in(zr_in), .ne_in(ne_in), .ov_in(ov_in),
        .zrEn_MEM(zrEn_MEM), .neEn_MEM(neEn_MEM), .ovEn_MEM(ovEn_MEM), .hlt_in(hlt_in),
        .wbData(wbData), .wbDst(wbDst), .wbWe(wbWe), .zr(zr), .ne(ne), .ov(ov),
        .hlt(hlt), .retireCnt(retireCnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic st, input logic fl, input logic v, input logic m2r,
                               input logic we, input logic [3:0] dst, input logic [15:0] mem,
                               input logic [15:0] alu, input logic [2:0] fin,
                               input logic [2:0] fen, input logic h);
        in_t r;
        r.stall = st; r.flush = fl; r.valid = v; r.m2r = m2r; r.we = we; r.dst = dst;
        r.mem = mem; r.alu = alu; r.fin = fin; r.fen = fen; r.hlt = h;
        return r;
    endfunction

    function automatic exp_t ex(input logic care, input logic we, input logic [3:0] dst,
                                input logic [15:0] data, input logic [2:0] flags,
                                input logic h, input logic [3:0] cnt);
        exp_t r;
        r.care = care; r.we = we; r.dst = dst; r.data = data; r.flags = flags;
        r.hlt = h; r.cnt = cnt;
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic apply(input in_t v);
        stall = v.stall; flush = v.flush; valid_in = v.valid; memToReg = v.m2r;
        regWe_in = v.we; dst_in = v.dst; memData = v.mem; aluResult = v.alu;
        {zr_in, ne_in, ov_in} = v.fin;
        {zrEn_MEM, neEn_MEM, ovEn_MEM} = v.fen;
        hlt_in = v.hlt;
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp({nm, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_t'(exp_q.pop_front());
        cmp({nm, "_wbWe"}, {31'd0, wbWe}, {31'd0, e.we});
        if (e.care) begin
            cmp({nm, "_wbDst"}, {28'd0, wbDst}, {28'd0, e.dst});
            cmp({nm, "_wbData"}, {16'd0, wbData}, {16'd0, e.data});
        end
        cmp({nm, "_flags"}, {29'd0, zr, ne, ov}, {29'd0, e.flags});
        cmp({nm, "_hlt"}, {31'd0, hlt}, {31'd0, e.hlt});
        cmp({nm, "_retireCnt"}, {28'd0, retireCnt}, {28'd0, (CNT_ON ? e.cnt : 4'd0)});
    endtask

    task automatic step(input string nm, input in_t v, input exp_t e);
        apply(v);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    rec_t tbl[5];
    in_t  add_r4, sub_r6, add_r1;
    exp_t held;

    initial begin
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 3'b000, 3'b000, 0));

        // Each row's expectation is the state after the edge that captures its inputs.
        tbl[0] = '{mk(0,0,1,0,1,4'h3,16'h0000,16'h1234,3'b010,3'b111,0), ex(1,1,4'h3,16'h1234,3'b010,0,4'd1)};
        tbl[1] = '{mk(0,0,1,1,1,4'h5,16'hBEEF,16'h7777,3'b111,3'b000,0), ex(1,1,4'h5,16'hBEEF,3'b010,0,4'd2)};
        tbl[2] = '{mk(0,0,0,0,1,4'h7,16'h0000,16'h5555,3'b101,3'b111,0), ex(1,0,4'h7,16'h5555,3'b010,0,4'd2)};
        tbl[3] = '{mk(0,0,1,0,0,4'h2,16'h0000,16'h0F0F,3'b101,3'b101,0), ex(1,0,4'h2,16'h0F0F,3'b111,0,4'd3)};
        tbl[4] = '{mk(0,0,1,0,1,4'h0,16'h0000,16'hAAAA,3'b000,3'b010,0), ex(1,1,4'h0,16'hAAAA,3'b101,0,4'd4)};

        @(posedge clk); #1;
        exp_q.push_back(ex(1, 0, 4'h0, 16'h0000, 3'b000, 0, 4'd0));
        check_out("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].ex);

        // Stall three cycles with a valid ADD waiting, then release.
        add_r4 = mk(1, 0, 1, 0, 1, 4'h4, 16'h0000, 16'h4444, 3'b000, 3'b111, 0);
        held   = ex(1, 1, 4'h0, 16'hAAAA, 3'b101, 0, 4'd4);
        for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), add_r4, held);
        add_r4.stall = 1'b0;
        step("stall_release", add_r4, ex(1, 1, 4'h4, 16'h4444, 3'b000, 0, 4'd5));

        // Flush squashes a flag-writing SUB; flush with stall holds; then SUB enters.
        sub_r6 = mk(0, 1, 1, 0, 1, 4'h6, 16'h0000, 16'h6666, 3'b100, 3'b100, 0);
        step("flush", sub_r6, ex(0, 0, 4'h0, 16'h0000, 3'b000, 0, 4'd5));
        sub_r6.stall = 1'b1;
        step("flush_stall", sub_r6, ex(0, 0, 4'h0, 16'h0000, 3'b000, 0, 4'd5));
        sub_r6.stall = 1'b0; sub_r6.flush = 1'b0;
        step("sub_r6", sub_r6, ex(1, 1, 4'h6, 16'h6666, 3'b100, 0, 4'd6));

        // HLT retires, then later instructions must not write, update flags or count.
        step("hlt", mk(0, 0, 1, 0, 1, 4'h1, 16'h0000, 16'h1111, 3'b000, 3'b000, 1),
             ex(1, 0, 4'h1, 16'h1111, 3'b100, 1, 4'd7));
        add_r1 = mk(0, 0, 1, 0, 1, 4'h1, 16'h0000, 16'h2222, 3'b010, 3'b111, 0);
        for (int i = 0; i < 4; i++) begin
            add_r1.stall = i[0];
            add_r1.flush = i[1];
            step($sformatf("post_hlt%0d", i), add_r1, ex(1, 0, 4'h1, 16'h1111, 3'b100, 1, 4'd7));
        end

        // Asynchronous reset mid-cycle clears immediately.
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(ex(1, 0, 4'h0, 16'h0000, 3'b000, 0, 4'd0));
        check_out("async_reset");
        @(posedge clk); #1;
        apply(mk(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 3'b000, 3'b000, 0));
        rst_n = 1'b1;

        // Sixteen retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            step($sformatf("wrap%0d", i),
                 mk(0, 0, 1, 0, 1, iv, 16'h0000, {12'h0, iv}, 3'b000, 3'b000, 0),
                 ex(1, 1, iv, {12'h0, iv}, 3'b000, 0, 4'(i + 1)));
        end

        cmp("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
